// File: rtl/dispatch_pkg.sv
// Shared dispatch constants and instruction length decode.
// Used by the dispatch queue and by decode.
package dispatch_pkg;

    localparam int WORD_W  = 64;
    localparam int MAX_LEN = 4;
    localparam int LEN_LSB = 0;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);
    localparam int LSEL_W  = $clog2(MAX_LEN);

    typedef logic [LEN_W-1:0] inst_len_t;

    // Encoded field holds len-1, so every word decodes to 1..MAX_LEN.
    function automatic inst_len_t decode_len(input logic [WORD_W-1:0] word);
        logic [LSEL_W-1:0] f;
        f = word[LEN_LSB +: LSEL_W];
        return inst_len_t'(f) + inst_len_t'(1);
    endfunction

endpackage

// File: rtl/var_len_dispatch_queue_if.sv
// Fetch-side push and decode-side lane handshakes of the dispatch queue.
// The queue takes the slave modport.
interface var_len_dispatch_queue_if
    import dispatch_pkg::*;
#(
    parameter int LANES   = 4,
    parameter int FETCH_W = 4
);
    localparam int IC_W = $clog2(FETCH_W + 1);

    logic                              in_valid;
    logic [IC_W-1:0]                   in_count;
    logic [FETCH_W*WORD_W-1:0]         in_words;
    logic                              in_ready;
    logic                              out_ready;
    logic [LANES-1:0]                  out_valid;
    logic [LANES*LEN_W-1:0]            out_len;
    logic [LANES*MAX_LEN*WORD_W-1:0]   out_inst;

    modport master (
        output in_valid, in_count, in_words, out_ready,
        input  in_ready, out_valid, out_len, out_inst
    );

    modport slave (
        input  in_valid, in_count, in_words, out_ready,
        output in_ready, out_valid, out_len, out_inst
    );

endinterface

// File: rtl/dispatch_ring_buf.sv
// Word ring storage: FETCH_W-wide write at a base index, indexed reads,
// and the decoded length of every entry for lane start chaining.
module dispatch_ring_buf
    import dispatch_pkg::*;
#(
    parameter int DEPTH   = 32,
    parameter int FETCH_W = 4,
    parameter int NRD     = 16,
    parameter int PTR_W   = $clog2(DEPTH)
) (
    input  logic                           clk,
    input  logic [FETCH_W-1:0]             wr_en,
    input  logic [PTR_W-1:0]               wr_base,
    input  logic [FETCH_W-1:0][WORD_W-1:0] wr_data,
    input  logic [NRD-1:0][PTR_W-1:0]      rd_idx,
    output logic [NRD-1:0][WORD_W-1:0]     rd_data,
    output inst_len_t [DEPTH-1:0]          len_all
);

    logic [DEPTH-1:0][WORD_W-1:0] mem_q;
    logic [DEPTH-1:0][WORD_W-1:0] mem_d;

    always_comb begin
        mem_d = mem_q;
        for (int j = 0; j < FETCH_W; j++) begin
            if (wr_en[j]) begin
                mem_d[wr_base + PTR_W'(j)] = wr_data[j];
            end
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Per-entry lengths let the top chain lane starts without
    // routing through the read ports.
    always_comb begin
        for (int r = 0; r < NRD; r++) begin
            rd_data[r] = mem_q[rd_idx[r]];
        end
        for (int i = 0; i < DEPTH; i++) begin
            len_all[i] = decode_len(mem_q[i]);
        end
    end

endmodule

// File: rtl/var_len_dispatch_queue.sv
// Dispatch-stage queue between fetch and decode: buffers variable-length
// instructions and presents up to LANES whole instructions per cycle.
module var_len_dispatch_queue
    import dispatch_pkg::*;
#(
    parameter int LANES   = 4,
    parameter int FETCH_W = 4,
    parameter int DEPTH   = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    var_len_dispatch_queue_if.slave  io
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int OFF_W = CNT_W + 1;
    localparam int IC_W  = $clog2(FETCH_W + 1);
    localparam int NRD   = LANES * MAX_LEN;

    logic [PTR_W-1:0]               head_q;
    logic [PTR_W-1:0]               head_d;
    logic [PTR_W-1:0]               tail_q;
    logic [PTR_W-1:0]               tail_d;
    logic [CNT_W-1:0]               count_q;
    logic [CNT_W-1:0]               count_d;

    inst_len_t [DEPTH-1:0]          len_all;
    logic [NRD-1:0][PTR_W-1:0]      rd_idx;
    logic [NRD-1:0][WORD_W-1:0]     rd_data;
    logic [FETCH_W-1:0]             wr_en;
    logic [FETCH_W-1:0][WORD_W-1:0] wr_data;

    logic [LANES-1:0]               lane_v;
    inst_len_t [LANES-1:0]          lane_len;
    logic [OFF_W-1:0]               lane_sum;
    logic [OFF_W-1:0]               pushed;
    logic [OFF_W-1:0]               popped;
    logic                           push_ok;

    dispatch_ring_buf #(
        .DEPTH   (DEPTH),
        .FETCH_W (FETCH_W),
        .NRD     (NRD),
        .PTR_W   (PTR_W)
    ) u_ring (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_base (tail_q),
        .wr_data (wr_data),
        .rd_idx  (rd_idx),
        .rd_data (rd_data),
        .len_all (len_all)
    );

    assign io.in_ready = (OFF_W'(DEPTH) - OFF_W'(count_q)) >= OFF_W'(FETCH_W);
    assign push_ok     = io.in_valid && io.in_ready && !flush;

    always_comb begin
        for (int j = 0; j < FETCH_W; j++) begin
            wr_en[j]   = push_ok && (IC_W'(j) < io.in_count);
            wr_data[j] = io.in_words[j*WORD_W +: WORD_W];
        end
    end

    // Lane k starts where lane k-1 ends; a lane issues only when all of its
    // words are buffered and every lower lane issues too.
    always_comb begin
        logic [OFF_W-1:0] off;
        logic [PTR_W-1:0] st;
        logic             prev;
        inst_len_t        l;
        lane_v   = '0;
        lane_len = '0;
        rd_idx   = '0;
        off      = '0;
        st       = '0;
        prev     = 1'b1;
        l        = '0;
        for (int k = 0; k < LANES; k++) begin
            st = head_q + off[PTR_W-1:0];
            l  = len_all[st];
            if (prev && ((off + OFF_W'(l)) <= OFF_W'(count_q))) begin
                lane_v[k]   = 1'b1;
                lane_len[k] = l;
            end
            prev = lane_v[k];
            for (int j = 0; j < MAX_LEN; j++) begin
                rd_idx[k*MAX_LEN + j] = st + PTR_W'(j);
            end
            off = off + OFF_W'(l);
        end
    end

    always_comb begin
        lane_sum = '0;
        for (int k = 0; k < LANES; k++) begin
            if (lane_v[k]) begin
                lane_sum = lane_sum + OFF_W'(lane_len[k]);
            end
        end
    end

    always_comb begin
        io.out_valid = lane_v;
        io.out_len   = '0;
        io.out_inst  = '0;
        for (int k = 0; k < LANES; k++) begin
            io.out_len[k*LEN_W +: LEN_W] = lane_len[k];
            for (int j = 0; j < MAX_LEN; j++) begin
                if (lane_v[k] && (LEN_W'(j) < lane_len[k])) begin
                    io.out_inst[(k*MAX_LEN + j)*WORD_W +: WORD_W] =
                        rd_data[k*MAX_LEN + j];
                end
            end
        end
    end

    always_comb begin
        pushed  = push_ok ? OFF_W'(io.in_count) : '0;
        popped  = io.out_ready ? lane_sum : '0;
        head_d  = head_q + popped[PTR_W-1:0];
        tail_d  = tail_q + pushed[PTR_W-1:0];
        count_d = CNT_W'(OFF_W'(count_q) + pushed - popped);
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_var_len_dispatch_queue.sv
// Scoreboard bench for var_len_dispatch_queue: directed pushes queue the
// expected lane bundles, a negedge monitor checks every retiring bundle.
module tb_var_len_dispatch_queue;
    import dispatch_pkg::*;

    localparam int LANES   = 4;
    localparam int FETCH_W = 4;
    localparam int DEPTH   = 32;
    localparam int LW      = LANES * MAX_LEN * WORD_W;

    typedef struct packed {
        logic [LANES-1:0]       v;
        logic [LANES*LEN_W-1:0] l;
        logic [LW-1:0]          w;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;

    var_len_dispatch_queue_if #(.LANES(LANES), .FETCH_W(FETCH_W)) io ();

    var_len_dispatch_queue #(
        .LANES   (LANES),
        .FETCH_W (FETCH_W),
        .DEPTH   (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .io    (io)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [255:0] act,
                       input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] hd(input logic [7:0] t, input int len);
        return {48'h0, t, 6'h0, 2'(len - 1)};
    endfunction

    function automatic logic [63:0] ct(input logic [7:0] t);
        return {48'h0, t, 8'h03};
    endfunction

    task automatic ex_clr();
        e = '0;
    endtask

    task automatic ex_lane(input int k, input int len, input logic [63:0] w0,
                           input logic [63:0] w1, input logic [63:0] w2,
                           input logic [63:0] w3);
        logic [63:0] ws [4];
        ws = '{w0, w1, w2, w3};
        e.v[k] = 1'b1;
        e.l[k*LEN_W +: LEN_W] = LEN_W'(len);
        for (int j = 0; j < len; j++) begin
            e.w[(k*MAX_LEN + j)*WORD_W +: WORD_W] = ws[j];
        end
    endtask

    task automatic ex_push();
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int cnt, input logic [63:0] w0,
                        input logic [63:0] w1, input logic [63:0] w2,
                        input logic [63:0] w3);
        io.in_valid = 1'b1;
        io.in_count = 3'(cnt);
        io.in_words = {w3, w2, w1, w0};
        tick();
        io.in_valid = 1'b0;
        io.in_count = '0;
        io.in_words = '0;
    endtask

    task automatic pop();
        io.out_ready = 1'b1;
        tick();
        io.out_ready = 1'b0;
    endtask

    // Any retiring bundle must match the oldest queued expectation.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (rst_n && !flush && io.out_ready && (io.out_valid != '0)) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sb_unexpected: got out_valid %b expected none",
                             io.out_valid);
                end else begin
                    x = sb.pop_front();
                    chk("lane_valid", 256'(io.out_valid), 256'(x.v));
                    chk("lane_len", 256'(io.out_len), 256'(x.l));
                    for (int k = 0; k < LANES; k++) begin
                        chk($sformatf("lane%0d_inst", k),
                            io.out_inst[k*256 +: 256], x.w[k*256 +: 256]);
                    end
                end
            end
        end
    end

    initial begin
        io.in_valid  = 1'b0;
        io.in_count  = '0;
        io.in_words  = '0;
        io.out_ready = 1'b0;

        // reset
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_in_ready", 256'(io.in_ready), 256'(1));
        chk("rst_out_valid", 256'(io.out_valid), 256'(0));
        chk("rst_out_len", 256'(io.out_len), 256'(0));
        chk("rst_out_inst_nz", 256'(io.out_inst != '0), 256'(0));
        rst_n = 1'b1;

        // four single-word instructions
        push(4, hd(8'h01, 1), hd(8'h02, 1), hd(8'h03, 1), hd(8'h04, 1));
        chk("t2_valid", 256'(io.out_valid), 256'(4'b1111));
        chk("t2_len", 256'(io.out_len), 256'({3'd1, 3'd1, 3'd1, 3'd1}));
        ex_clr();
        ex_lane(0, 1, hd(8'h01, 1), '0, '0, '0);
        ex_lane(1, 1, hd(8'h02, 1), '0, '0, '0);
        ex_lane(2, 1, hd(8'h03, 1), '0, '0, '0);
        ex_lane(3, 1, hd(8'h04, 1), '0, '0, '0);
        ex_push();
        pop();
        chk("t2_drained", 256'(io.out_valid), 256'(0));

        // len 4 then len 2 arriving partially
        push(4, hd(8'h10, 4), ct(8'h11), ct(8'h12), ct(8'h13));
        push(1, hd(8'h14, 2), '0, '0, '0);
        chk("t3_partial_valid", 256'(io.out_valid), 256'(4'b0001));
        chk("t3_len0", 256'(io.out_len[2:0]), 256'(4));
        push(1, ct(8'h15), '0, '0, '0);
        chk("t3_full_valid", 256'(io.out_valid), 256'(4'b0011));
        ex_clr();
        ex_lane(0, 4, hd(8'h10, 4), ct(8'h11), ct(8'h12), ct(8'h13));
        ex_lane(1, 2, hd(8'h14, 2), ct(8'h15), '0, '0);
        ex_push();
        pop();

        // walk head from 10 to 30, then span the wrap
        for (int i = 0; i < 5; i++) begin
            push(4, hd(8'(64 + 4*i), 1), hd(8'(65 + 4*i), 1),
                 hd(8'(66 + 4*i), 1), hd(8'(67 + 4*i), 1));
            ex_clr();
            for (int k = 0; k < 4; k++) begin
                ex_lane(k, 1, hd(8'(64 + 4*i + k), 1), '0, '0, '0);
            end
            ex_push();
            pop();
        end
        push(4, hd(8'h50, 4), ct(8'h51), ct(8'h52), ct(8'h53));
        push(1, hd(8'h54, 1), '0, '0, '0);
        chk("t4_wrap_valid", 256'(io.out_valid), 256'(4'b0011));
        ex_clr();
        ex_lane(0, 4, hd(8'h50, 4), ct(8'h51), ct(8'h52), ct(8'h53));
        ex_lane(1, 1, hd(8'h54, 1), '0, '0, '0);
        ex_push();
        pop();

        // fill to DEPTH-3, pop with a refused push in the same cycle
        for (int i = 0; i < 7; i++) begin
            push(4, hd(8'(128 + 4*i), 1), hd(8'(129 + 4*i), 1),
                 hd(8'(130 + 4*i), 1), hd(8'(131 + 4*i), 1));
        end
        chk("t5_ready_at_28", 256'(io.in_ready), 256'(1));
        push(1, hd(8'h9C, 1), '0, '0, '0);
        chk("t5_ready_at_29", 256'(io.in_ready), 256'(0));
        ex_clr();
        for (int k = 0; k < 4; k++) begin
            ex_lane(k, 1, hd(8'(128 + k), 1), '0, '0, '0);
        end
        ex_push();
        io.in_valid  = 1'b1;
        io.in_count  = 3'd4;
        io.in_words  = {4{hd(8'hEE, 1)}};
        io.out_ready = 1'b1;
        chk("t5_ready_pop_cycle", 256'(io.in_ready), 256'(0));
        tick();
        io.in_valid  = 1'b0;
        io.in_count  = '0;
        io.in_words  = '0;
        io.out_ready = 1'b0;
        chk("t5_ready_after_pop", 256'(io.in_ready), 256'(1));
        for (int p = 0; p < 6; p++) begin
            ex_clr();
            for (int k = 0; k < 4; k++) begin
                ex_lane(k, 1, hd(8'(132 + 4*p + k), 1), '0, '0, '0);
            end
            ex_push();
            pop();
        end
        ex_clr();
        ex_lane(0, 1, hd(8'h9C, 1), '0, '0, '0);
        ex_push();
        pop();
        chk("t5_empty", 256'(io.out_valid), 256'(0));

        // flush beats a simultaneous push and pop
        push(4, hd(8'hA0, 1), hd(8'hA1, 1), hd(8'hA2, 1), hd(8'hA3, 1));
        push(4, hd(8'hA4, 1), hd(8'hA5, 1), hd(8'hA6, 1), hd(8'hA7, 1));
        push(2, hd(8'hA8, 1), hd(8'hA9, 1), '0, '0);
        flush        = 1'b1;
        io.in_valid  = 1'b1;
        io.in_count  = 3'd4;
        io.in_words  = {4{hd(8'hDD, 1)}};
        io.out_ready = 1'b1;
        tick();
        flush        = 1'b0;
        io.in_valid  = 1'b0;
        io.in_count  = '0;
        io.in_words  = '0;
        io.out_ready = 1'b0;
        chk("t6_flush_valid", 256'(io.out_valid), 256'(0));
        chk("t6_flush_ready", 256'(io.in_ready), 256'(1));
        push(3, hd(8'hE0, 1), hd(8'hE1, 2), ct(8'hE2), '0);
        chk("t6_after_valid", 256'(io.out_valid), 256'(4'b0011));
        ex_clr();
        ex_lane(0, 1, hd(8'hE0, 1), '0, '0, '0);
        ex_lane(1, 2, hd(8'hE1, 2), ct(8'hE2), '0, '0);
        ex_push();
        pop();

        chk("sb_left_over", 256'(sb.size()), 256'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
